ns_txpkt_gen: RTL and testbench

- Test-traffic source that sits directly upstream of the CMAC tx port.
- Produces frame-data, meta-data and frame-counter packets on an AXI stream that feeds the CMAC and the tx packet counter monitoring that same stream.
- Software starts a burst of N packets of a chosen type with an inter-packet gap.
- The downstream per-size counters must then match exactly.

---
 rtl/ns_pkt_pkg.sv | 40 ++++
 rtl/ns_txpkt_beat_fmt.sv | 40 ++++
 rtl/ns_txpkt_gen.sv | 166 ++++++++++++++++
 tb/tb_ns_txpkt_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ns_pkt_pkg.sv
// Shared packet definitions for the tx traffic generator and the tx packet counter:
// packet lengths, pkt_type encoding and generator FSM states.
package ns_pkt_pkg;

    localparam logic [15:0] FRAME_DATA_LEN = 16'd4160;
    localparam logic [15:0] META_DATA_LEN  = 16'd192;
    localparam logic [15:0] FRAME_CTR_LEN  = 16'd68;

    typedef enum logic [1:0] {
        PKT_FRAME_DATA = 2'd0,
        PKT_META_DATA  = 2'd1,
        PKT_FRAME_CTR  = 2'd2,
        PKT_MIXED      = 2'd3
    } pkt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } gen_state_e;

    function automatic logic [15:0] pkt_len(input pkt_type_e t);
        case (t)
            PKT_META_DATA: pkt_len = META_DATA_LEN;
            PKT_FRAME_CTR: pkt_len = FRAME_CTR_LEN;
            default:       pkt_len = FRAME_DATA_LEN;
        endcase
    endfunction

    // Mixed bursts cycle frame-data -> meta-data -> frame-counter -> frame-data ...
    function automatic pkt_type_e next_mixed_type(input pkt_type_e t);
        case (t)
            PKT_FRAME_DATA: next_mixed_type = PKT_META_DATA;
            PKT_META_DATA:  next_mixed_type = PKT_FRAME_CTR;
            default:        next_mixed_type = PKT_FRAME_DATA;
        endcase
    endfunction

endpackage

// File: rtl/ns_txpkt_beat_fmt.sv
// Combinational beat formatter: from packet length, beat index and sequence number
// produces the lane-patterned tdata, the byte enables and the last-beat flag.
module ns_txpkt_beat_fmt
    import ns_pkt_pkg::*;
#(
    parameter int DW    = 512,
    parameter int SEQ_W = 16
) (
    input  logic [15:0]      len,
    input  logic [15:0]      beat_idx,
    input  logic [SEQ_W-1:0] seq,
    output logic [DW-1:0]    tdata,
    output logic [DW/8-1:0]  tkeep,
    output logic             tlast
);

    localparam int BPB   = DW / 8;
    localparam int LANES = DW / 32;

    logic [15:0] base;
    logic [15:0] remaining;
    logic [31:0] lane;

    always_comb begin
        base      = beat_idx * 16'(BPB);
        remaining = len - base;
        tlast     = (remaining <= 16'(BPB));
        lane      = {16'(seq), beat_idx};
        for (int i = 0; i < BPB; i++) begin
            tkeep[i] = (16'(i) < remaining);
        end
        // Bytes past the valid length are forced to zero.
        for (int l = 0; l < LANES; l++) begin
            for (int b = 0; b < 4; b++) begin
                tdata[l*32 + b*8 +: 8] = tkeep[l*4 + b] ? lane[b*8 +: 8] : 8'h00;
            end
        end
    end

endmodule

// File: rtl/ns_txpkt_gen.sv
// Test-traffic burst generator feeding the CMAC tx AXI stream.
// Optional mixed-type bursts (pkt_type 3) are enabled by defining NS_TXPKT_GEN_MIXED_EN.
module ns_txpkt_gen
    import ns_pkt_pkg::*;
#(
    parameter int DW    = 512,
    parameter int SEQ_W = 16
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic            start,
    input  logic [1:0]      pkt_type,
    input  logic [31:0]     pkt_count,
    input  logic [7:0]      gap_cycles,
    output logic            busy,
    output logic            done,
    output logic [63:0]     packets_sent,
    output logic [DW-1:0]   axis_tx_tdata,
    output logic [DW/8-1:0] axis_tx_tkeep,
    output logic            axis_tx_tlast,
    output logic            axis_tx_tvalid,
    input  logic            axis_tx_tready
);

    logic [3:0]       rst_sync_q, rst_sync_d;
    logic             rst_n;
    gen_state_e       state_q, state_d;
    pkt_type_e        cur_type_q, cur_type_d;
    logic             mixed_q, mixed_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [7:0]       gap_q, gap_d;
    logic [7:0]       gap_ctr_q, gap_ctr_d;
    logic [15:0]      beat_q, beat_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [63:0]      sent_q, sent_d;
    logic             type_ok;
    logic             valid;
    logic [DW-1:0]    fmt_tdata;
    logic [DW/8-1:0]  fmt_tkeep;
    logic             fmt_tlast;

    // Reset asserts asynchronously everywhere; release is seen 4 clocks later.
    assign rst_sync_d = {rst_sync_q[2:0], 1'b1};
    assign rst_n      = rst_sync_q[3];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync_q <= 4'b0000;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

`ifdef NS_TXPKT_GEN_MIXED_EN
    assign type_ok = 1'b1;
`else
    assign type_ok = (pkt_type != 2'(PKT_MIXED));
`endif

    ns_txpkt_beat_fmt #(
        .DW   (DW),
        .SEQ_W(SEQ_W)
    ) u_beat_fmt (
        .len     (pkt_len(cur_type_q)),
        .beat_idx(beat_q),
        .seq     (seq_q),
        .tdata   (fmt_tdata),
        .tkeep   (fmt_tkeep),
        .tlast   (fmt_tlast)
    );

    always_comb begin
        state_d    = state_q;
        cur_type_d = cur_type_q;
        mixed_d    = mixed_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        gap_ctr_d  = gap_ctr_q;
        beat_d     = beat_q;
        seq_d      = seq_q;
        sent_d     = sent_q;
        valid      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && type_ok) begin
                    mixed_d    = (pkt_type == 2'(PKT_MIXED));
                    cur_type_d = (pkt_type == 2'(PKT_MIXED)) ? PKT_FRAME_DATA : pkt_type_e'(pkt_type);
                    cnt_d      = pkt_count;
                    gap_d      = gap_cycles;
                    beat_d     = 16'd0;
                    seq_d      = '0;
                    state_d    = (pkt_count == 32'd0) ? ST_FIN : ST_SEND;
                end
            end
            ST_SEND: begin
                valid = 1'b1;
                if (axis_tx_tready) begin
                    if (fmt_tlast) begin
                        sent_d = sent_q + 64'd1;
                        cnt_d  = cnt_q - 32'd1;
                        seq_d  = seq_q + SEQ_W'(1);
                        beat_d = 16'd0;
                        if (mixed_q) begin
                            cur_type_d = next_mixed_type(cur_type_q);
                        end
                        // No gap after the final packet of a burst.
                        if (cnt_q == 32'd1) begin
                            state_d = ST_FIN;
                        end else if (gap_q != 8'd0) begin
                            state_d   = ST_GAP;
                            gap_ctr_d = gap_q;
                        end
                    end else begin
                        beat_d = beat_q + 16'd1;
                    end
                end
            end
            ST_GAP: begin
                gap_ctr_d = gap_ctr_q - 8'd1;
                if (gap_ctr_q == 8'd1) begin
                    state_d = ST_SEND;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_type_q <= PKT_FRAME_DATA;
            mixed_q    <= 1'b0;
            cnt_q      <= 32'd0;
            gap_q      <= 8'd0;
            gap_ctr_q  <= 8'd0;
            beat_q     <= 16'd0;
            seq_q      <= '0;
            sent_q     <= 64'd0;
        end else begin
            state_q    <= state_d;
            cur_type_q <= cur_type_d;
            mixed_q    <= mixed_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            gap_ctr_q  <= gap_ctr_d;
            beat_q     <= beat_d;
            seq_q      <= seq_d;
            sent_q     <= sent_d;
        end
    end

    // Data outputs are held at zero whenever no beat is offered.
    assign axis_tx_tvalid = valid;
    assign axis_tx_tdata  = valid ? fmt_tdata : '0;
    assign axis_tx_tkeep  = valid ? fmt_tkeep : '0;
    assign axis_tx_tlast  = valid & fmt_tlast;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_FIN);
    assign packets_sent   = sent_q;

endmodule

// File: tb/tb_ns_txpkt_gen.sv
// Directed bench for ns_txpkt_gen: table of bursts plus hand-written reset,
// zero-count and mixed-type sequences.
module tb_ns_txpkt_gen;

    localparam int DW = 512;

    logic         clk = 1'b0;
    logic         aresetn;
    logic         start;
    logic [1:0]   pkt_type;
    logic [31:0]  pkt_count;
    logic [7:0]   gap_cycles;
    logic         busy;
    logic         done;
    logic [63:0]  packets_sent;
    logic [511:0] axis_tx_tdata;
    logic [63:0]  axis_tx_tkeep;
    logic         axis_tx_tlast;
    logic         axis_tx_tvalid;
    logic         axis_tx_tready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ns_txpkt_gen #(.DW(DW), .SEQ_W(16)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .start         (start),
        .pkt_type      (pkt_type),
        .pkt_count     (pkt_count),
        .gap_cycles    (gap_cycles),
        .busy          (busy),
        .done          (done),
        .packets_sent  (packets_sent),
        .axis_tx_tdata (axis_tx_tdata),
        .axis_tx_tkeep (axis_tx_tkeep),
        .axis_tx_tlast (axis_tx_tlast),
        .axis_tx_tvalid(axis_tx_tvalid),
        .axis_tx_tready(axis_tx_tready)
    );

    typedef struct {
        logic [1:0] ptype;
        int         count;
        int         gap;
        int         rdy_pct;
        bit         inject;
        int         total_beats;
        longint     sent_after;
    } burst_t;

    burst_t      tbl[5];
    burst_t      rec;
    int          beats_tab[3];
    logic [63:0] lkeep_tab[3];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] exp_data(input int seq, input int beat, input logic [63:0] keep);
        logic [511:0] d;
        for (int l = 0; l < 16; l++) d[l*32 +: 32] = {seq[15:0], beat[15:0]};
        for (int b = 0; b < 64; b++) if (!keep[b]) d[b*8 +: 8] = 8'h00;
        return d;
    endfunction

    task automatic check_idle(input string nm);
        chk({nm, "_tvalid"}, axis_tx_tvalid, 0);
        chk({nm, "_tdata"}, axis_tx_tdata, 0);
        chk({nm, "_tkeep"}, axis_tx_tkeep, 0);
        chk({nm, "_tlast"}, axis_tx_tlast, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
    endtask

    // Starts a burst at the current negedge and follows it to its done pulse.
    task automatic run_burst(input burst_t r);
        int hs = 0, pkt = 0, beat = 0, gap_run = 0, cyc = 0, cur_t, nb;
        bit wait_next = 0, prev_stall = 0, prev_last = 0, last_hs, seen_done = 0;
        logic [63:0]  ek, hk;
        logic [511:0] hd;
        logic         hl;
        pkt_type = r.ptype; pkt_count = r.count; gap_cycles = 8'(r.gap); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_latency", busy, 1);
        chk("tvalid_latency", axis_tx_tvalid, 1);
        while (!seen_done && cyc < 4000) begin
            cyc++;
            last_hs = 0;
            if (r.inject && cyc == 2) begin
                start = 1'b1; pkt_type = 2'd0; pkt_count = 32'd7; gap_cycles = 8'd3;
            end else if (r.inject && cyc == 3) begin
                start = 1'b0;
            end
            axis_tx_tready = (r.rdy_pct >= 100) ? 1'b1 : 1'($urandom_range(0, 99) < r.rdy_pct);
            if (done) begin
                seen_done = 1;
                chk("done_after_last", prev_last, 1);
                chk("total_beats", hs, r.total_beats);
                chk("packets_in_burst", pkt, r.count);
                chk("packets_sent", packets_sent, r.sent_after);
                chk("done_tvalid", axis_tx_tvalid, 0);
            end else begin
                if (prev_stall) begin
                    chk("stall_tvalid", axis_tx_tvalid, 1);
                    chk("stall_tdata", axis_tx_tdata, hd);
                    chk("stall_tkeep", axis_tx_tkeep, hk);
                    chk("stall_tlast", axis_tx_tlast, hl);
                end
                prev_stall = 0;
                if (axis_tx_tvalid) begin
                    if (wait_next) begin
                        chk("gap_cycles", gap_run, r.gap);
                        wait_next = 0;
                    end
                    if (axis_tx_tready) begin
                        cur_t = (r.ptype == 2'd3) ? (pkt % 3) : int'(r.ptype);
                        nb = beats_tab[cur_t];
                        ek = (beat == nb - 1) ? lkeep_tab[cur_t] : {64{1'b1}};
                        chk("tkeep", axis_tx_tkeep, ek);
                        chk("tlast", axis_tx_tlast, beat == nb - 1);
                        chk("tdata", axis_tx_tdata, exp_data(pkt, beat, ek));
                        hs++;
                        if (beat == nb - 1) begin
                            pkt++;
                            beat = 0;
                            last_hs = 1;
                            if (pkt < r.count) begin
                                wait_next = 1;
                                gap_run = 0;
                            end
                        end else begin
                            beat++;
                        end
                    end else begin
                        prev_stall = 1;
                        hd = axis_tx_tdata; hk = axis_tx_tkeep; hl = axis_tx_tlast;
                    end
                end else begin
                    gap_run++;
                end
            end
            prev_last = last_hs;
            @(negedge clk);
        end
        if (!seen_done) chk("done_timeout", 0, 1);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got running want finished");
        $fatal(1);
    end

    initial begin
        beats_tab[0] = 65; lkeep_tab[0] = {64{1'b1}};
        beats_tab[1] = 3;  lkeep_tab[1] = {64{1'b1}};
        beats_tab[2] = 2;  lkeep_tab[2] = 64'h000000000000000F;
        //         ptype count gap rdy inject beats sent_after
        tbl[0] = '{2'd2, 1, 0, 100, 1'b0, 2,   64'd1};
        tbl[1] = '{2'd0, 3, 0, 100, 1'b0, 195, 64'd4};
        tbl[2] = '{2'd1, 4, 5, 50,  1'b0, 12,  64'd8};
        tbl[3] = '{2'd2, 3, 2, 100, 1'b0, 6,   64'd11};
        tbl[4] = '{2'd2, 2, 0, 100, 1'b1, 4,   64'd13};

        aresetn = 1'b0; start = 1'b0; pkt_type = 2'd0; pkt_count = 32'd0;
        gap_cycles = 8'd0; axis_tx_tready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("in_reset");
        chk("in_reset_sent", packets_sent, 0);
        aresetn = 1'b1;
        repeat (4) @(negedge clk);
        check_idle("after_release");
        chk("after_release_sent", packets_sent, 0);
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_burst(tbl[i]);
            @(negedge clk);
        end

        // Zero-length burst: done with no beats.
        pkt_type = 2'd2; pkt_count = 32'd0; gap_cycles = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cnt0_busy", busy, 1);
        chk("cnt0_done", done, 1);
        chk("cnt0_tvalid", axis_tx_tvalid, 0);
        @(negedge clk);
        check_idle("cnt0_end");
        chk("cnt0_sent", packets_sent, 13);

`ifdef NS_TXPKT_GEN_MIXED_EN
        rec = '{2'd3, 4, 1, 100, 1'b0, 135, 64'd17};
        run_burst(rec);
        @(negedge clk);
`else
        pkt_type = 2'd3; pkt_count = 32'd4; gap_cycles = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_idle("mixed_off");
            @(negedge clk);
        end
        chk("mixed_off_sent", packets_sent, 13);
`endif

        // Reset while frame-data beat 30 is on the bus.
        axis_tx_tready = 1'b1;
        pkt_type = 2'd0; pkt_count = 32'd1; gap_cycles = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("pre_reset_tvalid", axis_tx_tvalid, 1);
        chk("pre_reset_beat", axis_tx_tdata[15:0], 30);
        aresetn = 1'b0;
        #1;
        check_idle("mid_reset");
        chk("mid_reset_sent", packets_sent, 0);
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_idle("resync");
        end
        @(negedge clk);
        rec = '{2'd2, 1, 0, 100, 1'b0, 2, 64'd1};
        run_burst(rec);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
